audio_triangle: RTL and testbench
=================================

Name: audio_triangle

Overview:
- Direct-digital-synthesis triangle-wave generator for the audio synth chain.
- A phase accumulator advances by a programmable frequency word every clock. The top phase bits fold into an 8-bit unsigned triangle sample.
- Runs at 12.5 MHz system clock. The output is continuous and is sampled downstream at 48 kHz.

Parameters:
- PHASE_W, 27, phase accumulator width. Output frequency = freq_i * f_clk / 2^PHASE_W; with 12.5 MHz, freq_i=4723 gives ~439.86 Hz.
- FREQ_W, 16, frequency-word width.
- OUT_W, 8, sample width.

Ports:
- clk_i  input  1  system clock, rising edge.
- rstn_i  input  1  reset, asynchronous, active-low.
- freq_i  input  FREQ_W  phase increment per clock, unsigned. Sampled every cycle.
- sample_data_o  output  OUT_W  unsigned triangle sample, 0..255.

Behaviour:
- One clock domain. Reset is asynchronous and active-low; all flops clear while rstn_i=0.
- phase_ff (PHASE_W bits):
  - reset value 0;
  - each cycle phase_ff <= phase_ff + zero_ext(freq_i);
  - wraps modulo 2^PHASE_W, no saturation, no overflow flag.
- Triangle fold: msb = phase_ff[PHASE_W-1], seg = phase_ff[PHASE_W-2 -: OUT_W].
  - tri = msb ? ~seg : seg.
  - Rising half goes 0..255; falling half goes 255..0. Each extreme is held twice as long as an interior code.
- Output register:
  - sample_data_o <= tri each cycle; reset value 0.
  - Latency: sample_data_o at edge n+1 reflects phase_ff after edge n.
- freq_i changes take effect on the next accumulation, with phase continuous (no reset, no glitch).
- freq_i=0: phase frozen, output constant.
- Reset mid-operation: phase and output go to 0 immediately (async). Accumulation resumes on the first rising edge after rstn_i deasserts.
- No valid/ready handshake; the output is valid every cycle after reset.

Decomposition:
- Package audio_synth_pkg:
  - localparams PHASE_W=27, FREQ_W=16, OUT_W=8;
  - typedefs phase_t, freq_t, sample_t.
- One natural sub-module, audio_phase_acc (phase accumulator with async reset). It is reusable by the saw/square/sine generators.
- The fold and output register live in audio_triangle.

Test Plan:
- Reset value:
  - Stimulus: hold rstn_i=0 for 2 cycles with freq_i=4723.
  - Required response: sample_data_o=0 throughout; it rises above 0 only after release.
- Fold, freq_i=32768:
  - After release, output steps +1 every 8 clocks.
  - Reaches 255 around clock 2048, then descends.
  - Back to 0 at clock 4096 (period 4096 clocks); pattern repeats exactly.
- Zero frequency:
  - Stimulus: freq_i=0 after reset.
  - Required response: sample_data_o stays 0 indefinitely.
  - Then set freq_i=32768 mid-run: ramp starts from 0 with no discontinuity.
- 440 Hz:
  - Stimulus: freq_i=4723 for 1 s (12.5e6 clocks); record a sample every 260 clocks (48 kHz) to audio_triangle.wav.
  - Required response:
    - period ≈ 28418 clocks (≈439.86 Hz);
    - min 0, max 255;
    - symmetric rise/fall within ±1 code.
- Wrap, freq_i=16'hFFFF:
  - Phase wraps every ≈2048 clocks.
  - Output continuous: adjacent-cycle difference ≤1 code; no jump at the 2^27 wrap.
- Async reset mid-ramp:
  - Stimulus: assert rstn_i between clock edges while output ≈128.
  - Required response: output goes to 0 without waiting for a clock edge; after release the ramp restarts from 0.

Source files
------------

// File: rtl/audio_synth_pkg.sv
// Shared constants and types for the audio synth chain.
// PHASE_W : phase accumulator width (27 bits; f_out = freq * f_clk / 2^27)
// FREQ_W  : frequency word width (16 bits)
// OUT_W   : audio sample width (8 bits, unsigned)
package audio_synth_pkg;

  localparam int unsigned PHASE_W = 27;
  localparam int unsigned FREQ_W  = 16;
  localparam int unsigned OUT_W   = 8;

  typedef logic [PHASE_W-1:0] phase_t;
  typedef logic [FREQ_W-1:0]  freq_t;
  typedef logic [OUT_W-1:0]   sample_t;

endpackage

// File: rtl/audio_phase_acc.sv
// DDS phase accumulator shared by the waveform generators.
// Ports:
//   clk_i   : system clock, rising edge
//   rstn_i  : asynchronous active-low reset, clears the phase to 0
//   freq_i  : unsigned phase increment, added every clock
//   phase_o : current phase, wraps modulo 2^PHASE_W
module audio_phase_acc
  import audio_synth_pkg::*;
(
  input  logic   clk_i,
  input  logic   rstn_i,
  input  freq_t  freq_i,
  output phase_t phase_o
);

  phase_t phase_ff;

  // Natural modulo-2^PHASE_W wrap; no saturation.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      phase_ff <= '0;
    end else begin
      phase_ff <= phase_ff + phase_t'(freq_i);
    end
  end

  assign phase_o = phase_ff;

endmodule

// File: rtl/audio_triangle.sv
// DDS triangle-wave generator.
// Ports:
//   clk_i         : system clock, rising edge
//   rstn_i        : asynchronous active-low reset
//   freq_i        : unsigned phase increment per clock
//   sample_data_o : registered unsigned triangle sample, 0..255
module audio_triangle
  import audio_synth_pkg::*;
(
  input  logic    clk_i,
  input  logic    rstn_i,
  input  freq_t   freq_i,
  output sample_t sample_data_o
);

  phase_t  phase;
  sample_t seg;
  sample_t fold;
  sample_t sample_ff;
  logic    unused_phase_lsbs;

  audio_phase_acc u_phase_acc (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .freq_i  (freq_i),
    .phase_o (phase)
  );

  // The phase MSB selects the half-period: rising uses the next OUT_W bits
  // directly, falling uses their complement, so both extremes are held twice.
  always_comb begin
    seg  = phase[PHASE_W-2 -: OUT_W];
    fold = phase[PHASE_W-1] ? ~seg : seg;
  end

  assign unused_phase_lsbs = ^phase[PHASE_W-OUT_W-2:0];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sample_ff <= '0;
    end else begin
      sample_ff <= fold;
    end
  end

  assign sample_data_o = sample_ff;

endmodule

// File: tb/tb_audio_triangle.sv
module tb_audio_triangle;

  localparam longint unsigned PMOD = 64'd1 << 27;
  localparam longint unsigned HALF = 64'd1 << 26;
  localparam longint unsigned STEP = 64'd1 << 18;

  logic        clk;
  logic        rstn;
  logic [15:0] freq;
  logic [7:0]  sample;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  longint unsigned m_phase;
  int unsigned     m_out;

  audio_triangle dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .freq_i        (freq),
    .sample_data_o (sample)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Triangle from phase by plain arithmetic: rise 0..255 over the first half,
  // fall 255..0 over the second.
  function automatic int unsigned tri_of(input longint unsigned p);
    if (p < HALF) return int'(p / STEP);
    else          return 255 - int'((p - HALF) / STEP);
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model at the edge, compare at the falling edge.
  task automatic tick(input string name);
    @(posedge clk);
    if (rstn) begin
      m_out   = tri_of(m_phase);
      m_phase = (m_phase + longint'(freq)) % PMOD;
    end
    @(negedge clk);
    check(name, sample, m_out);
  endtask

  // Reset held for two cycles with a non-zero frequency; output must stay 0.
  task automatic do_reset(input logic [15:0] f_during);
    @(negedge clk);
    rstn = 1'b0;
    freq = f_during;
    m_phase = 0;
    m_out   = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset_hold", sample, 0);
    end
    rstn = 1'b1;
  endtask

  typedef struct {
    logic [15:0] f;
    int unsigned n;
    int unsigned exp;
  } vec_t;

  vec_t vecs[$];
  int unsigned prev;
  int unsigned maxdiff;
  int unsigned d;

  initial begin
    rstn = 1'b0;
    freq = '0;
    m_phase = 0;
    m_out   = 0;

    vecs.push_back('{16'd32768, 9,    1});
    vecs.push_back('{16'd32768, 2048, 255});
    vecs.push_back('{16'd32768, 2049, 255});
    vecs.push_back('{16'd32768, 3073, 127});
    vecs.push_back('{16'd32768, 4096, 0});
    vecs.push_back('{16'd32768, 4097, 0});
    vecs.push_back('{16'd32768, 4105, 1});
    vecs.push_back('{16'd0,     100,  0});
    vecs.push_back('{16'hFFFF,  2,    0});
    vecs.push_back('{16'hFFFF,  5,    0});
    vecs.push_back('{16'hFFFF,  6,    1});
    vecs.push_back('{16'd4723,  1001, 18});

    // Table: reset, run n clocks at a fixed frequency, compare final sample.
    foreach (vecs[k]) begin
      do_reset(16'd4723);
      freq = vecs[k].f;
      for (int unsigned i = 0; i < vecs[k].n; i++) tick("table_model");
      check($sformatf("table_%0d", k), sample, vecs[k].exp);
    end

    // First edge after release must lift the phase but not the output yet.
    do_reset(16'd4723);
    freq = 16'd4723;
    tick("release_first");
    check("release_latency", sample, 0);

    // Zero frequency holds the output, then the ramp starts cleanly from 0.
    do_reset(16'd4723);
    freq = 16'd0;
    for (int i = 0; i < 300; i++) tick("zero_freq");
    check("zero_hold", sample, 0);
    freq = 16'd32768;
    for (int i = 0; i < 40; i++) tick("zero_to_ramp");
    check("zero_to_ramp_end", sample, 4);

    // Maximum frequency: continuity across several phase wraps.
    do_reset(16'd4723);
    freq = 16'hFFFF;
    prev = 0;
    maxdiff = 0;
    for (int i = 0; i < 5000; i++) begin
      tick("wrap_model");
      d = (sample > prev) ? sample - prev : prev - sample;
      if (d > maxdiff) maxdiff = d;
      prev = sample;
    end
    check("wrap_max_step", maxdiff, 1);

    // Asynchronous reset mid-ramp, asserted between edges.
    do_reset(16'd4723);
    freq = 16'd32768;
    for (int i = 0; i < 1030; i++) tick("pre_async");
    check("pre_async_level", sample, 128);
    @(posedge clk);
    m_out   = tri_of(m_phase);
    m_phase = (m_phase + longint'(freq)) % PMOD;
    #2 rstn = 1'b0;
    #1 check("async_clear", sample, 0);
    m_phase = 0;
    m_out   = 0;
    @(negedge clk);
    @(negedge clk);
    check("async_hold", sample, 0);
    rstn = 1'b1;
    for (int i = 0; i < 17; i++) tick("post_async");
    check("post_async_ramp", sample, 2);

    // Randomised frequency changes against the model, phase continuous.
    do_reset(16'd4723);
    for (int s = 0; s < 30; s++) begin
      case ($urandom_range(0, 5))
        0:       freq = 16'd0;
        1:       freq = 16'hFFFF;
        default: freq = 16'($urandom_range(0, 65535));
      endcase
      for (int unsigned i = 0; i < $urandom_range(1, 300); i++) tick("random_model");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
